// File: rtl/xy_dac_pkg.sv
// Shared types and constants for the XY DAC scheduler.
package xy_dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE_X,
        LATCH_X,
        DRIVE_Y,
        LATCH_Y
    } xy_state_t;

    localparam int unsigned SETTLE_DEFAULT = 2;

endpackage

// File: rtl/rate_tick_div.sv
// Sample-rate divider: one-cycle tick every rate_div+1 enabled cycles.
module rate_tick_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] rate_div,
    output logic       tick
);

    logic [7:0] cnt;

    // Compare with >= so that lowering rate_div mid-count fires at once instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= rate_div) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 8'd1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/xy_dac_scheduler.sv
// Time-multiplexes X/Y samples onto one shared DAC bus with per-channel latch strobes.
// Optional beam blanking output is enabled by defining XY_DAC_BLANK_EN.
module xy_dac_scheduler
    import xy_dac_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] rate_div,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    input  logic       clr_overrun,
    output logic       sample_tick,
    output logic [7:0] dac_bus,
    output logic       dac_latch_x,
    output logic       dac_latch_y,
    output logic       busy,
    output logic       overrun,
    output logic       blank
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    xy_state_t  state, state_next;
    logic [3:0] settle_cnt, settle_next;
    logic       capture;
    logic [7:0] x_hold, y_hold;

    rate_tick_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .rate_div (rate_div),
        .tick     (sample_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = '0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick) begin
                    state_next = DRIVE_X;
                    capture    = 1'b1;
                end
            end
            DRIVE_X: begin
                if (settle_cnt == SETTLE_LAST) state_next = LATCH_X;
                else                           settle_next = settle_cnt + 4'd1;
            end
            LATCH_X: state_next = DRIVE_Y;
            DRIVE_Y: begin
                if (settle_cnt == SETTLE_LAST) state_next = LATCH_Y;
                else                           settle_next = settle_cnt + 4'd1;
            end
            LATCH_Y: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hold registers only change on capture, so y_hold is also the bus value left over in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (capture) begin
            x_hold <= x_data;
            y_hold <= y_data;
        end
    end

    // A set from a dropped tick wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           overrun <= 1'b0;
        else if (sample_tick && state != IDLE) overrun <= 1'b1;
        else if (clr_overrun)                 overrun <= 1'b0;
    end

    assign dac_bus     = (state == DRIVE_X || state == LATCH_X) ? x_hold : y_hold;
    assign dac_latch_x = (state == LATCH_X);
    assign dac_latch_y = (state == LATCH_Y);
    assign busy        = (state != IDLE);

`ifdef XY_DAC_BLANK_EN
    assign blank = busy | sample_tick;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_xy_dac_scheduler.sv
// Directed self-checking bench for xy_dac_scheduler (SETTLE=2); honours XY_DAC_BLANK_EN.
module tb_xy_dac_scheduler;

`ifdef XY_DAC_BLANK_EN
    localparam int BLANK_EXP = 7;
`else
    localparam int BLANK_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] rate_div;
    logic [7:0] x_data;
    logic [7:0] y_data;
    logic       clr_overrun;
    logic       sample_tick;
    logic [7:0] dac_bus;
    logic       dac_latch_x;
    logic       dac_latch_y;
    logic       busy;
    logic       overrun;
    logic       blank;

    int tests = 0;
    int errors = 0;
    int tick_cnt, lx_cnt, ly_cnt, blank_cnt;

    always #5 clk = ~clk;

    xy_dac_scheduler #(.SETTLE(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rate_div    (rate_div),
        .x_data      (x_data),
        .y_data      (y_data),
        .clr_overrun (clr_overrun),
        .sample_tick (sample_tick),
        .dac_bus     (dac_bus),
        .dac_latch_x (dac_latch_x),
        .dac_latch_y (dac_latch_y),
        .busy        (busy),
        .overrun     (overrun),
        .blank       (blank)
    );

    task automatic apply_stimulus(input logic en, input logic [7:0] rd, input logic [7:0] x,
                                  input logic [7:0] y, input logic clr);
        enable      = en;
        rate_div    = rd;
        x_data      = x;
        y_data      = y;
        clr_overrun = clr;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic check_count(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_counts();
        tick_cnt  = 0;
        lx_cnt    = 0;
        ly_cnt    = 0;
        blank_cnt = 0;
    endtask

    task automatic accumulate();
        tick_cnt  += int'(sample_tick);
        lx_cnt    += int'(dac_latch_x);
        ly_cnt    += int'(dac_latch_y);
        blank_cnt += int'(blank);
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, 8'd0, 8'h00, 8'h00, 1'b0);
        step(2);
        check_bit ("rst_tick",  sample_tick, 1'b0);
        check_byte("rst_bus",   dac_bus,     8'h00);
        check_bit ("rst_lx",    dac_latch_x, 1'b0);
        check_bit ("rst_ly",    dac_latch_y, 1'b0);
        check_bit ("rst_busy",  busy,        1'b0);
        check_bit ("rst_ovr",   overrun,     1'b0);
        check_bit ("rst_blank", blank,       1'b0);

        // Nominal transfer: rate_div=6 gives a 7-cycle period, exactly one transfer long.
        rst_n = 1'b1;
        apply_stimulus(1'b1, 8'd6, 8'h12, 8'h34, 1'b0);
        step(6);
        check_bit("t1_no_early_tick", sample_tick, 1'b0);
        step(1);
        check_bit("t1_first_tick", sample_tick, 1'b1);
        check_bit("t1_idle_at_tick", busy, 1'b0);
        clear_counts();
        for (int i = 0; i < 7; i++) begin
            accumulate();
            if (i == 1) check_bit("t1_busy", busy, 1'b1);
            if (i == 3) begin
                check_bit ("t1_lx",     dac_latch_x, 1'b1);
                check_byte("t1_bus_x",  dac_bus,     8'h12);
            end
            if (i == 6) begin
                check_bit ("t1_ly",     dac_latch_y, 1'b1);
                check_byte("t1_bus_y",  dac_bus,     8'h34);
            end
            step(1);
        end
        check_count("t1_ticks", tick_cnt, 1);
        check_count("t1_lx_cnt", lx_cnt, 1);
        check_count("t1_ly_cnt", ly_cnt, 1);
        check_count("t1_blank_cycles", blank_cnt, BLANK_EXP);
        check_bit ("t1_second_tick", sample_tick, 1'b1);
        check_bit ("t1_idle_again", busy, 1'b0);
        check_bit ("t1_no_overrun", overrun, 1'b0);
        check_byte("t1_bus_holds", dac_bus, 8'h34);

        // Drop enable as the next transfer starts: it must complete, no further ticks.
        apply_stimulus(1'b0, 8'd6, 8'h12, 8'h34, 1'b0);
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) accumulate();
            if (i == 6) check_bit("dis_ly_completes", dac_latch_y, 1'b1);
            step(1);
        end
        check_count("dis_no_ticks", tick_cnt, 0);
        check_bit("dis_idle", busy, 1'b0);

        // rate_div=5: every other tick lands in LATCH_Y and is dropped.
        apply_stimulus(1'b1, 8'd5, 8'h56, 8'h78, 1'b0);
        step(6);
        check_bit("ov_tick1", sample_tick, 1'b1);
        step(1);
        check_bit("ov_busy", busy, 1'b1);
        apply_stimulus(1'b1, 8'd5, 8'h9A, 8'hBC, 1'b0);
        step(2);
        check_bit ("ov_lx", dac_latch_x, 1'b1);
        check_byte("ov_bus_x", dac_bus, 8'h56);
        step(3);
        check_bit ("ov_tick2", sample_tick, 1'b1);
        check_bit ("ov_ly", dac_latch_y, 1'b1);
        check_byte("ov_bus_y", dac_bus, 8'h78);
        step(1);
        check_bit ("ov_set", overrun, 1'b1);
        check_bit ("ov_dropped_not_busy", busy, 1'b0);
        check_byte("ov_bus_unchanged", dac_bus, 8'h78);
        apply_stimulus(1'b1, 8'd5, 8'h9A, 8'hBC, 1'b1);
        step(1);
        check_bit("ov_cleared", overrun, 1'b0);
        apply_stimulus(1'b1, 8'd5, 8'h9A, 8'hBC, 1'b0);
        step(3);
        check_bit("ov_still_idle", busy, 1'b0);
        step(1);
        check_bit("ov_tick3", sample_tick, 1'b1);
        step(3);
        check_bit ("ov_lx3", dac_latch_x, 1'b1);
        check_byte("ov_bus_x3", dac_bus, 8'h9A);
        apply_stimulus(1'b0, 8'd5, 8'h9A, 8'hBC, 1'b0);
        step(5);
        check_bit("ov_drain_idle", busy, 1'b0);

        // rate_div=0: tick every cycle, one transfer per 7 cycles; set beats clear.
        apply_stimulus(1'b1, 8'd0, 8'h9A, 8'hBC, 1'b0);
        step(1);
        clear_counts();
        for (int i = 0; i < 14; i++) begin
            accumulate();
            if (i == 4) apply_stimulus(1'b1, 8'd0, 8'h9A, 8'hBC, 1'b1);
            if (i == 5) begin
                apply_stimulus(1'b1, 8'd0, 8'h9A, 8'hBC, 1'b0);
                check_bit("r0_set_beats_clr", overrun, 1'b1);
            end
            step(1);
        end
        check_count("r0_ticks", tick_cnt, 14);
        check_count("r0_lx_cnt", lx_cnt, 2);
        check_count("r0_ly_cnt", ly_cnt, 2);
        check_bit("r0_overrun", overrun, 1'b1);
        apply_stimulus(1'b0, 8'd200, 8'h9A, 8'hBC, 1'b0);
        step(8);
        check_bit("r0_drain_idle", busy, 1'b0);

        // Lower rate_div below the running count: tick next cycle, then a clean 11-cycle period.
        apply_stimulus(1'b1, 8'd200, 8'h9A, 8'hBC, 1'b0);
        step(50);
        check_bit("rd_no_tick_at_50", sample_tick, 1'b0);
        apply_stimulus(1'b1, 8'd10, 8'h9A, 8'hBC, 1'b0);
        step(1);
        check_bit("rd_immediate_tick", sample_tick, 1'b1);
        step(10);
        check_bit("rd_no_wrap_tick", sample_tick, 1'b0);
        step(1);
        check_bit("rd_reload_tick", sample_tick, 1'b1);

        // Asynchronous reset in DRIVE_Y.
        step(4);
        check_bit ("rs_in_drive_y", busy, 1'b1);
        check_byte("rs_bus_y", dac_bus, 8'hBC);
        rst_n = 1'b0;
        #1;
        check_byte("rs_bus", dac_bus, 8'h00);
        check_bit ("rs_busy", busy, 1'b0);
        check_bit ("rs_lx", dac_latch_x, 1'b0);
        check_bit ("rs_ly", dac_latch_y, 1'b0);
        check_bit ("rs_tick", sample_tick, 1'b0);
        check_bit ("rs_ovr", overrun, 1'b0);
        check_bit ("rs_blank", blank, 1'b0);
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            accumulate();
            step(1);
        end
        check_count("rs_no_ly", ly_cnt, 0);
        rst_n = 1'b1;
        step(10);
        check_bit("rs_no_early_tick", sample_tick, 1'b0);
        step(1);
        check_bit("rs_first_tick", sample_tick, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
